// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard scheduler.
//   - Forwarding-select encodings used on every fwd_* output.
//   - Tnew/Tuse values for each instruction class as produced by the
//     D-stage decoder (cycles counted from the D stage).
package hazard_ctrl_pkg;

  // Forward source selects. RF and PIPE share code 0: "take the normal path".
  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_PIPE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  // Result latency (Tnew) per producer class.
  localparam logic [2:0] TNEW_CAL = 3'd2;
  localparam logic [2:0] TNEW_LW  = 3'd3;
  localparam logic [2:0] TNEW_JAL = 3'd0;

  // Operand need time (Tuse) per consumer class.
  localparam logic [2:0] TUSE_CAL   = 3'd1;
  localparam logic [2:0] TUSE_LW    = 3'd1;
  localparam logic [2:0] TUSE_BEQ   = 3'd0;
  localparam logic [2:0] TUSE_SW_RS = 3'd1;
  localparam logic [2:0] TUSE_SW_RT = 3'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bus between the D-stage decoder / datapath muxes and the hazard scheduler.
//   Decoder -> scheduler : A1_D, A2_D, A3_D, Tuse1_D, Tuse2_D, Tnew_D
//   Scheduler -> datapath: stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
//                          fwd_rt_M, stall_cnt
// master = decoder/datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int TW    = 3,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    A1_D;
  logic [AW-1:0]    A2_D;
  logic [AW-1:0]    A3_D;
  logic [TW-1:0]    Tuse1_D;
  logic [TW-1:0]    Tuse2_D;
  logic [TW-1:0]    Tnew_D;
  logic             stall;
  logic [1:0]       fwd_rs_D;
  logic [1:0]       fwd_rt_D;
  logic [1:0]       fwd_rs_E;
  logic [1:0]       fwd_rt_E;
  logic             fwd_rt_M;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output A1_D, A2_D, A3_D, Tuse1_D, Tuse2_D, Tnew_D,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
  );

  modport slave (
    input  A1_D, A2_D, A3_D, Tuse1_D, Tuse2_D, Tnew_D,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_stage_reg.sv
// One pipeline stage of register-usage tracking (used for E, M and W).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_clear         : load a bubble (all fields 0) instead of the inputs
//   i_dec           : decrement Tnew (clamped at 0) while loading
//   i_a1/i_a2/i_a3  : source/destination addresses from the previous stage
//   i_tnew          : result latency from the previous stage
//   o_a1/o_a2/o_a3/o_tnew : registered stage contents
module hazard_stage_reg #(
  parameter int AW = 5,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_dec,
  input  logic [AW-1:0] i_a1,
  input  logic [AW-1:0] i_a2,
  input  logic [AW-1:0] i_a3,
  input  logic [TW-1:0] i_tnew,
  output logic [AW-1:0] o_a1,
  output logic [AW-1:0] o_a2,
  output logic [AW-1:0] o_a3,
  output logic [TW-1:0] o_tnew
);

  // Tnew counts down one per stage and never wraps below zero.
  function automatic logic [TW-1:0] f_sat0_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  logic [AW-1:0] r_a1;
  logic [AW-1:0] r_a2;
  logic [AW-1:0] r_a3;
  logic [TW-1:0] r_tnew;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_a1   <= '0;
      r_a2   <= '0;
      r_a3   <= '0;
      r_tnew <= '0;
    end else begin
      r_a1   <= i_a1;
      r_a2   <= i_a2;
      r_a3   <= i_a3;
      r_tnew <= i_dec ? f_sat0_dec(i_tnew) : i_tnew;
    end
  end

  assign o_a1   = r_a1;
  assign o_a2   = r_a2;
  assign o_a3   = r_a3;
  assign o_tnew = r_tnew;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage F/D/E/M/W core.
// Tracks in-flight destinations and remaining result latency in E/M/W,
// raises stall when a D operand is needed before its producer can supply
// it, and picks forwarding sources for D, E and M operands.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (D-stage usage info in; stall,
//                forward selects and saturating stall counter out)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AW    = 5,
  parameter int TW    = 3,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  logic [AW-1:0]    w_e_a1, w_e_a2, w_e_a3;
  logic [AW-1:0]    w_m_a1, w_m_a2, w_m_a3;
  logic [AW-1:0]    w_w_a1, w_w_a2, w_w_a3;
  logic [TW-1:0]    w_e_tnew, w_m_tnew, w_w_tnew;
  logic             w_stall;
  logic [1:0]       w_fwd_rs_d, w_fwd_rt_d, w_fwd_rs_e, w_fwd_rt_e;
  logic             w_fwd_rt_m;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_unused;

  // A stalled instruction stays in D; E receives a bubble instead.
  hazard_stage_reg #(.AW(AW), .TW(TW)) u_stage_e (
    .clk(clk), .reset(reset), .i_clear(w_stall), .i_dec(1'b1),
    .i_a1(bus.A1_D), .i_a2(bus.A2_D), .i_a3(bus.A3_D), .i_tnew(bus.Tnew_D),
    .o_a1(w_e_a1), .o_a2(w_e_a2), .o_a3(w_e_a3), .o_tnew(w_e_tnew)
  );

  hazard_stage_reg #(.AW(AW), .TW(TW)) u_stage_m (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_dec(1'b1),
    .i_a1(w_e_a1), .i_a2(w_e_a2), .i_a3(w_e_a3), .i_tnew(w_e_tnew),
    .o_a1(w_m_a1), .o_a2(w_m_a2), .o_a3(w_m_a3), .o_tnew(w_m_tnew)
  );

  hazard_stage_reg #(.AW(AW), .TW(TW)) u_stage_w (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_dec(1'b1),
    .i_a1(w_m_a1), .i_a2(w_m_a2), .i_a3(w_m_a3), .i_tnew(w_m_tnew),
    .o_a1(w_w_a1), .o_a2(w_w_a2), .o_a3(w_w_a3), .o_tnew(w_w_tnew)
  );

  // $zero is hard-wired, so address 0 never creates a dependency.
  function automatic logic f_match(input logic [AW-1:0] a3, input logic [AW-1:0] a);
    return (a != '0) && (a3 == a);
  endfunction

  function automatic logic f_ready(input logic [AW-1:0] a3, input logic [TW-1:0] t,
                                   input logic [AW-1:0] a);
    return f_match(a3, a) && (t == '0);
  endfunction

  always_comb begin
    // Only E and M can block: W results are always complete.
    w_stall = (f_match(w_e_a3, bus.A1_D) && (w_e_tnew > bus.Tuse1_D)) ||
              (f_match(w_m_a3, bus.A1_D) && (w_m_tnew > bus.Tuse1_D)) ||
              (f_match(w_e_a3, bus.A2_D) && (w_e_tnew > bus.Tuse2_D)) ||
              (f_match(w_m_a3, bus.A2_D) && (w_m_tnew > bus.Tuse2_D));

    // Nearest ready producer wins; non-ready matches are skipped.
    if      (f_ready(w_e_a3, w_e_tnew, bus.A1_D)) w_fwd_rs_d = FWD_E;
    else if (f_ready(w_m_a3, w_m_tnew, bus.A1_D)) w_fwd_rs_d = FWD_M;
    else if (f_ready(w_w_a3, w_w_tnew, bus.A1_D)) w_fwd_rs_d = FWD_W;
    else                                          w_fwd_rs_d = FWD_RF;

    if      (f_ready(w_e_a3, w_e_tnew, bus.A2_D)) w_fwd_rt_d = FWD_E;
    else if (f_ready(w_m_a3, w_m_tnew, bus.A2_D)) w_fwd_rt_d = FWD_M;
    else if (f_ready(w_w_a3, w_w_tnew, bus.A2_D)) w_fwd_rt_d = FWD_W;
    else                                          w_fwd_rt_d = FWD_RF;

    if      (f_ready(w_m_a3, w_m_tnew, w_e_a1)) w_fwd_rs_e = FWD_M;
    else if (f_ready(w_w_a3, w_w_tnew, w_e_a1)) w_fwd_rs_e = FWD_W;
    else                                        w_fwd_rs_e = FWD_PIPE;

    if      (f_ready(w_m_a3, w_m_tnew, w_e_a2)) w_fwd_rt_e = FWD_M;
    else if (f_ready(w_w_a3, w_w_tnew, w_e_a2)) w_fwd_rt_e = FWD_W;
    else                                        w_fwd_rt_e = FWD_PIPE;

    w_fwd_rt_m = f_ready(w_w_a3, w_w_tnew, w_m_a2);
  end

  // Saturating stall-cycle counter; reset wins over a concurrent stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd_rs_D  = w_fwd_rs_d;
  assign bus.fwd_rt_D  = w_fwd_rt_d;
  assign bus.fwd_rs_E  = w_fwd_rs_e;
  assign bus.fwd_rt_E  = w_fwd_rt_e;
  assign bus.fwd_rt_M  = w_fwd_rt_m;
  assign bus.stall_cnt = r_stall_cnt;

  // Source addresses past their last consumer are carried but not read.
  assign w_unused = ^{w_m_a1, w_w_a1, w_w_a2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a timeline model (each issued instruction remembers its issue
// cycle and the cycle its result becomes available).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] d_a1 = '0, d_a2 = '0, d_a3 = '0;
  logic [2:0] d_tu1 = '0, d_tu2 = '0, d_tn = '0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(5), .TW(3), .CNT_W(16)) bus16 ();
  hazard_ctrl_if #(.AW(5), .TW(3), .CNT_W(6))  bus6 ();

  assign bus16.A1_D = d_a1;  assign bus6.A1_D = d_a1;
  assign bus16.A2_D = d_a2;  assign bus6.A2_D = d_a2;
  assign bus16.A3_D = d_a3;  assign bus6.A3_D = d_a3;
  assign bus16.Tuse1_D = d_tu1;  assign bus6.Tuse1_D = d_tu1;
  assign bus16.Tuse2_D = d_tu2;  assign bus6.Tuse2_D = d_tu2;
  assign bus16.Tnew_D = d_tn;    assign bus6.Tnew_D = d_tn;

  hazard_ctrl #(.AW(5), .TW(3), .CNT_W(16)) dut (.clk(clk), .reset(rst), .bus(bus16));
  hazard_ctrl #(.AW(5), .TW(3), .CNT_W(6))  dut_sat (.clk(clk), .reset(rst), .bus(bus6));

  int vecs = 0;
  int errs = 0;

  // ---------------- timeline reference model ----------------
  typedef struct {
    int a1; int a2; int a3; int t_issue; int t_ready;
  } rec_t;
  rec_t q[$];
  int now = 0;
  int cnt = 0;

  bit m_stall;
  int m_fd_rs, m_fd_rt, m_fe_rs, m_fe_rt, m_fm_rt, m_c16, m_c6;

  // age 1 = E, 2 = M, 3 = W
  function automatic int idx_at(int age);
    foreach (q[i]) if (now - q[i].t_issue == age) return i;
    return -1;
  endfunction

  function automatic int remt(int i);
    int r;
    r = q[i].t_ready - now;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit hit(int i, int a);
    if (i < 0 || a == 0) return 1'b0;
    return q[i].a3 == a;
  endfunction

  function automatic bit blocks(int a, int tuse);
    for (int age = 1; age <= 2; age++) begin
      int i;
      i = idx_at(age);
      if (hit(i, a) && remt(i) > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Oldest-to-youngest scan, so the youngest ready producer overwrites.
  function automatic int fwd_from(int a, int nearest_age);
    int code;
    code = 0;
    for (int age = 3; age >= nearest_age; age--) begin
      int i;
      i = idx_at(age);
      if (hit(i, a) && remt(i) == 0) code = age;
    end
    return code;
  endfunction

  task automatic model_eval();
    int i;
    m_stall = blocks(int'(d_a1), int'(d_tu1)) || blocks(int'(d_a2), int'(d_tu2));
    m_fd_rs = fwd_from(int'(d_a1), 1);
    m_fd_rt = fwd_from(int'(d_a2), 1);
    i = idx_at(1);
    m_fe_rs = (i >= 0) ? fwd_from(q[i].a1, 2) : 0;
    m_fe_rt = (i >= 0) ? fwd_from(q[i].a2, 2) : 0;
    i = idx_at(2);
    m_fm_rt = (i >= 0 && fwd_from(q[i].a2, 3) == 3) ? 1 : 0;
    m_c16 = (cnt > 65535) ? 65535 : cnt;
    m_c6  = (cnt > 63) ? 63 : cnt;
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (m_stall) begin
      cnt++;
    end else begin
      q.push_back('{int'(d_a1), int'(d_a2), int'(d_a3), now, now + int'(d_tn)});
    end
    now++;
    while (q.size() > 0 && now - q[0].t_issue > 3) void'(q.pop_front());
  endtask

  // Drive one D-stage instruction for the coming cycle and evaluate the model.
  task automatic apply(input bit r, input int a1, input int a2, input int a3,
                       input int tu1, input int tu2, input int tn);
    @(negedge clk);
    rst = r;
    d_a1 = 5'(a1); d_a2 = 5'(a2); d_a3 = 5'(a3);
    d_tu1 = 3'(tu1); d_tu2 = 3'(tu2); d_tn = 3'(tn);
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply(1, 3, 4, 5, 0, 0, 3);
    tick();
    apply(0, 7, 9, 7, 0, 0, 3);
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%0d exp=0", bus16.stall); end
    vecs++; if ({bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E, bus16.fwd_rt_M} !== 9'd0) begin
      errs++; $display("FAIL reset_fwd got=%0h exp=0", {bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E, bus16.fwd_rt_M});
    end
    vecs++; if (bus16.stall_cnt !== 16'd0 || bus6.stall_cnt !== 6'd0) begin
      errs++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus16.stall_cnt, bus6.stall_cnt);
    end
    tick();
  endtask

  task automatic test_lw_use();
    do_reset();
    apply(0, 2, 0, 1, TUSE_LW, 0, TNEW_LW);              // lw $1
    tick();
    apply(0, 1, 4, 5, TUSE_CAL, TUSE_CAL, TNEW_CAL);      // addu $5,$1,$4
    vecs++; if (bus16.stall !== 1'b1) begin errs++; $display("FAIL lw_use_stall got=%0d exp=1", bus16.stall); end
    tick();
    apply(0, 1, 4, 5, TUSE_CAL, TUSE_CAL, TNEW_CAL);
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL lw_use_release got=%0d exp=0", bus16.stall); end
    vecs++; if (bus16.stall_cnt !== 16'd1) begin errs++; $display("FAIL lw_use_cnt got=%0d exp=1", bus16.stall_cnt); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    // lw has reached W (its data is ready there) while addu sits in E.
    vecs++; if (bus16.fwd_rs_E !== FWD_W) begin errs++; $display("FAIL lw_use_fwd_rs_E got=%0d exp=%0d", bus16.fwd_rs_E, FWD_W); end
    tick();
  endtask

  task automatic test_cal_beq();
    do_reset();
    apply(0, 6, 7, 2, TUSE_CAL, TUSE_CAL, TNEW_CAL);      // addu $2
    tick();
    apply(0, 2, 0, 0, TUSE_BEQ, TUSE_BEQ, 0);             // beq $2,$0
    vecs++; if (bus16.stall !== 1'b1) begin errs++; $display("FAIL beq_stall got=%0d exp=1", bus16.stall); end
    tick();
    apply(0, 2, 0, 0, TUSE_BEQ, TUSE_BEQ, 0);
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL beq_release got=%0d exp=0", bus16.stall); end
    vecs++; if (bus16.fwd_rs_D !== FWD_M) begin errs++; $display("FAIL beq_fwd_rs_D got=%0d exp=%0d", bus16.fwd_rs_D, FWD_M); end
    tick();
  endtask

  task automatic test_jal_jr();
    do_reset();
    apply(0, 0, 0, 31, 0, 0, TNEW_JAL);                    // jal
    tick();
    apply(0, 31, 0, 0, 0, 0, 0);                           // jr $31
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL jr_stall got=%0d exp=0", bus16.stall); end
    vecs++; if (bus16.fwd_rs_D !== FWD_E) begin errs++; $display("FAIL jr_fwd_rs_D got=%0d exp=%0d", bus16.fwd_rs_D, FWD_E); end
    tick();
  endtask

  task automatic test_sw_fwd();
    do_reset();
    apply(0, 4, 0, 3, TUSE_CAL, 0, TNEW_CAL);              // ori $3,$4
    tick();
    apply(0, 5, 3, 0, TUSE_SW_RS, TUSE_SW_RT, 0);          // sw $3,0($5)
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL sw_stall got=%0d exp=0", bus16.stall); end
    vecs++; if (bus16.fwd_rt_D !== FWD_RF) begin errs++; $display("FAIL sw_fwd_rt_D got=%0d exp=0", bus16.fwd_rt_D); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    vecs++; if (bus16.fwd_rt_E !== FWD_M) begin errs++; $display("FAIL sw_fwd_rt_E got=%0d exp=%0d", bus16.fwd_rt_E, FWD_M); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    vecs++; if (bus16.fwd_rt_M !== 1'b1) begin errs++; $display("FAIL sw_fwd_rt_M got=%0d exp=1", bus16.fwd_rt_M); end
    tick();
  endtask

  task automatic test_zero();
    do_reset();
    apply(0, 0, 0, 0, TUSE_LW, 0, TNEW_LW);                // lw $0
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 0, TUSE_BEQ, TUSE_BEQ, 0);
      vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL zero_stall[%0d] got=%0d exp=0", k, bus16.stall); end
      vecs++; if ({bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E, bus16.fwd_rt_M} !== 9'd0) begin
        errs++; $display("FAIL zero_fwd[%0d] got=%0h exp=0", k, {bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E, bus16.fwd_rt_M});
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    bit found;
    do_reset();
    // Self-dependent lw with Tuse 0: stalls two of every three cycles.
    for (int k = 0; k < 240; k++) begin
      apply(0, 1, 0, 1, TUSE_BEQ, 0, TNEW_LW);
      vecs++; if (bus16.stall !== m_stall) begin errs++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", k, bus16.stall, m_stall); end
      tick();
    end
    apply(0, 1, 0, 1, TUSE_BEQ, 0, TNEW_LW);
    vecs++; if (bus6.stall_cnt !== 6'h3F) begin errs++; $display("FAIL sat_cnt6 got=%0d exp=63", bus6.stall_cnt); end
    vecs++; if (bus16.stall_cnt !== 16'(m_c16)) begin errs++; $display("FAIL sat_cnt16 got=%0d exp=%0d", bus16.stall_cnt, m_c16); end
    found = m_stall;
    for (int k = 0; k < 6 && !found; k++) begin
      tick();
      apply(0, 1, 0, 1, TUSE_BEQ, 0, TNEW_LW);
      found = m_stall;
    end
    vecs++; if (!found) begin errs++; $display("FAIL sat_find_stall got=no_stall exp=stall within 6 cycles"); end
    tick();
    apply(1, 1, 0, 1, TUSE_BEQ, 0, TNEW_LW);               // reset mid-stall
    tick();
    apply(0, 1, 0, 1, TUSE_BEQ, 0, TNEW_LW);
    vecs++; if (bus16.stall !== 1'b0) begin errs++; $display("FAIL sat_rst_stall got=%0d exp=0", bus16.stall); end
    vecs++; if (bus16.stall_cnt !== 16'd0 || bus6.stall_cnt !== 6'd0) begin
      errs++; $display("FAIL sat_rst_cnt got=%0d/%0d exp=0/0", bus16.stall_cnt, bus6.stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    int a1, a2, a3, tu1, tu2, tn;
    bit r;
    do_reset();
    a1 = 0; a2 = 0; a3 = 0; tu1 = 0; tu2 = 0; tn = 0;
    for (int k = 0; k < 500; k++) begin
      // D inputs are held while the scheduler stalls, as the real front end does.
      if (!m_stall || k == 0) begin
        a1 = $urandom_range(0, 5); a2 = $urandom_range(0, 5); a3 = $urandom_range(0, 5);
        tu1 = $urandom_range(0, 2); tu2 = $urandom_range(0, 2); tn = $urandom_range(0, 3);
      end
      r = ($urandom_range(0, 59) == 0);
      apply(r, a1, a2, a3, tu1, tu2, tn);
      vecs++;
      if (bus16.stall !== m_stall || bus16.fwd_rs_D !== 2'(m_fd_rs) || bus16.fwd_rt_D !== 2'(m_fd_rt) ||
          bus16.fwd_rs_E !== 2'(m_fe_rs) || bus16.fwd_rt_E !== 2'(m_fe_rt) || bus16.fwd_rt_M !== 1'(m_fm_rt) ||
          bus16.stall_cnt !== 16'(m_c16) || bus6.stall_cnt !== 6'(m_c6)) begin
        errs++;
        $display("FAIL rand[%0d] got st=%0d fD=%0d/%0d fE=%0d/%0d fM=%0d c=%0d/%0d exp st=%0d fD=%0d/%0d fE=%0d/%0d fM=%0d c=%0d/%0d",
                 k, bus16.stall, bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E, bus16.fwd_rt_M,
                 bus16.stall_cnt, bus6.stall_cnt, m_stall, m_fd_rs, m_fd_rt, m_fe_rs, m_fe_rt, m_fm_rt, m_c16, m_c6);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lw_use();
    test_cal_beq();
    test_jal_jr();
    test_sw_fwd();
    test_zero();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
